// File: rtl/hamming_tx_queue_if.sv
// Encoder-to-UART queue bundle: codeword push side, transmitter launch side and status.
// The slave side belongs to the queue; the master side drives codewords and the transmitter busy flag.
interface hamming_tx_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic              ena;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              tx_busy;
    logic              clear_ovf;
    logic              tx_start;
    logic [DATA_W:0]   tx_data;
    logic [LW-1:0]     level;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              tx_err;

    modport slave (
        input  ena, in_valid, in_data, tx_busy, clear_ovf,
        output tx_start, tx_data, level, empty, full, overflow, tx_err
    );

    modport master (
        output ena, in_valid, in_data, tx_busy, clear_ovf,
        input  tx_start, tx_data, level, empty, full, overflow, tx_err
    );
endinterface

// File: rtl/hamming_tx_queue.sv
// Codeword FIFO feeding the UART: pushes land one edge later, tx_start follows on the next edge.
// Pushes while full are dropped (sticky overflow); a launch that never sees tx_busy is abandoned (sticky tx_err).
module hamming_tx_queue #(
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 7,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    hamming_tx_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            overflow_q, overflow_d;
    logic            tx_err_q, tx_err_d;
    logic            tx_start_q, tx_start_d;
    logic [DATA_W:0] tx_data_q, tx_data_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic push;
    logic drop;
    logic pop;

    // full_q is the pre-edge value, so a pop in the same cycle does not make room for a push.
    assign push = bus.ena & bus.in_valid & ~full_q;
    assign drop = bus.ena & bus.in_valid & full_q;
    assign pop  = (state_q == S_LAUNCH);

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        overflow_d = bus.clear_ovf ? 1'b0 : overflow_q;
        tx_err_d   = bus.clear_ovf ? 1'b0 : tx_err_q;
        if (drop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.ena && !empty_q && !bus.tx_busy) begin
                    state_d    = S_LAUNCH;
                    tx_start_d = 1'b1;
                    tx_data_d  = {1'b0, mem_q[rd_ptr_q]};
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    // The popped codeword is abandoned rather than retried.
                    tx_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        empty_d  = (level_d == '0);
        full_d   = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            tx_err_q   <= tx_err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: level and the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.level    = level_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_err   = tx_err_q;
endmodule

// File: tb/tb_hamming_tx_queue.sv
// Directed bench for hamming_tx_queue: inputs change and outputs are sampled on the falling edge.
module tb_hamming_tx_queue;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hamming_tx_queue_if #(.DEPTH(4), .DATA_W(7)) bus ();

    hamming_tx_queue #(.DEPTH(4), .DATA_W(7), .BUSY_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_launch(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.tx_start === 1'b1) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Well-behaved transmitter: busy for a short frame right after a launch.
    task automatic serve_frame();
        bus.tx_busy = 1'b1;
        repeat (3) tick();
        bus.tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.ena       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.tx_busy   = 1'b0;
        bus.clear_ovf = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.level, bus.empty, bus.full, bus.overflow, bus.tx_err} !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got start=%b data=%h level=%0d empty=%b full=%b ovf=%b err=%b, need 0 00 0 1 0 0 0",
                     bus.tx_start, bus.tx_data, bus.level, bus.empty, bus.full, bus.overflow, bus.tx_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h2D;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.level !== 3'd1 || bus.tx_start !== 1'b0 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL single_push: got level=%0d start=%b empty=%b, need 1 0 0", bus.level, bus.tx_start, bus.empty);
        end
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h2D) begin
            errors++;
            $display("FAIL single_launch: got start=%b data=%h, need 1 2d", bus.tx_start, bus.tx_data);
        end
        tick();
        checks++;
        if (bus.tx_start !== 1'b0 || bus.level !== 3'd0 || bus.empty !== 1'b1 || bus.tx_data !== 8'h2D) begin
            errors++;
            $display("FAIL single_pop: got start=%b level=%0d empty=%b data=%h, need 0 0 1 2d",
                     bus.tx_start, bus.level, bus.empty, bus.tx_data);
        end
        bus.tx_busy = 1'b1;
        repeat (9) tick();
        checks++;
        if (bus.tx_err !== 1'b0 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_wait_done: got err=%b start=%b, need 0 0", bus.tx_err, bus.tx_start);
        end
        bus.tx_busy = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0] words [5];
        logic [7:0] expd  [4];
        bit         seen;
        int         starts;
        words = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
        expd  = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            tick();
        end
        checks++;
        if (bus.level !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_four: got level=%0d full=%b ovf=%b, need 4 1 0", bus.level, bus.full, bus.overflow);
        end
        bus.in_data = words[4];
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL push_when_full: got level=%0d ovf=%b, need 4 1", bus.level, bus.overflow);
        end
        bus.tx_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_launch(seen);
            checks++;
            if (!seen || bus.tx_data !== expd[k]) begin
                errors++;
                $display("FAIL fifo_order[%0d]: got seen=%b data=%h, need 1 %h", k, seen, bus.tx_data, expd[k]);
            end
            serve_frame();
        end
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tx_start === 1'b1) starts++;
            tick();
        end
        checks++;
        if (starts != 0 || bus.level !== 3'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL dropped_never_sent: got extra_starts=%0d level=%0d empty=%b, need 0 0 1", starts, bus.level, bus.empty);
        end
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_overflow: got ovf=%b, need 0", bus.overflow);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        bus.tx_busy  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h0A;
        tick();
        bus.in_data  = 7'h7F;
        tick();
        bus.in_valid = 1'b0;
        wait_launch(seen);
        checks++;
        if (!seen || bus.tx_data !== 8'h0A) begin
            errors++;
            $display("FAIL timeout_first_launch: got seen=%b data=%h, need 1 0a", seen, bus.tx_data);
        end
        repeat (4) tick();
        checks++;
        if (bus.tx_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got err=%b, need 0", bus.tx_err);
        end
        tick();
        checks++;
        if (bus.tx_err !== 1'b1 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: got err=%b start=%b, need 1 0", bus.tx_err, bus.tx_start);
        end
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h7F) begin
            errors++;
            $display("FAIL timeout_next_launch: got start=%b data=%h, need 1 7f", bus.tx_start, bus.tx_data);
        end
        repeat (8) tick();
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        checks++;
        if (bus.tx_err !== 1'b0 || bus.level !== 3'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b level=%0d ovf=%b, need 0 0 0", bus.tx_err, bus.level, bus.overflow);
        end
    endtask

    task automatic test_full_pop_push();
        logic [6:0] words [4];
        words = '{7'h19, 7'h2A, 7'h3B, 7'h4C};
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h19 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL full_launch: got start=%b data=%h full=%b, need 1 19 1", bus.tx_start, bus.tx_data, bus.full);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h5A;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.level !== 3'd3 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL pop_push_full: got ovf=%b level=%0d full=%b, need 1 3 0", bus.overflow, bus.level, bus.full);
        end
        bus.tx_busy = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int starts;
        checks++;
        if (bus.level !== 3'd3) begin
            errors++;
            $display("FAIL reset_precondition: got level=%0d, need 3", bus.level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.level, bus.empty, bus.full, bus.overflow} !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got start=%b data=%h level=%0d empty=%b full=%b ovf=%b, need 0 00 0 1 0 0",
                     bus.tx_start, bus.tx_data, bus.level, bus.empty, bus.full, bus.overflow);
        end
        tick();
        rst_n       = 1'b1;
        bus.tx_busy = 1'b0;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.tx_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_discards: got starts=%0d empty=%b, need 0 1", starts, bus.empty);
        end
    endtask

    task automatic test_enable();
        int starts;
        bit seen;
        bus.ena = 1'b0;
        starts  = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'h33;
            tick();
            if (bus.tx_start === 1'b1) starts++;
            bus.in_valid = 1'b0;
            tick();
            if (bus.tx_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0 || bus.level !== 3'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL ena_low_push: got starts=%0d level=%0d empty=%b, need 0 0 1", starts, bus.level, bus.empty);
        end
        bus.ena      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h6C;
        tick();
        bus.in_data  = 7'h13;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h6C) begin
            errors++;
            $display("FAIL ena_launch: got start=%b data=%h, need 1 6c", bus.tx_start, bus.tx_data);
        end
        bus.tx_busy = 1'b1;
        tick();
        tick();
        bus.ena = 1'b0;
        tick();
        bus.tx_busy = 1'b0;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.tx_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0 || bus.level !== 3'd1 || bus.tx_err !== 1'b0) begin
            errors++;
            $display("FAIL ena_low_frame_done: got starts=%0d level=%0d err=%b, need 0 1 0", starts, bus.level, bus.tx_err);
        end
        bus.ena = 1'b1;
        tick();
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h13) begin
            errors++;
            $display("FAIL ena_resume: got start=%b data=%h, need 1 13", bus.tx_start, bus.tx_data);
        end
        serve_frame();
        wait_launch(seen);
        checks++;
        if (seen || bus.level !== 3'd0) begin
            errors++;
            $display("FAIL ena_drained: got extra_start=%b level=%0d, need 0 0", seen, bus.level);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_full_pop_push();
        test_reset_mid_frame();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
